// File: rtl/squeeze_stream.sv
// Squeeze phase of a sponge construction: emits rate chunks, requesting a
// permutation between chunks. Optional perm_count port under SQUEEZE_PERM_COUNT_EN.
module squeeze_stream #(
  parameter int CWIDTH      = 320,
  parameter int RWIDTH      = 32,
  parameter int OUT_WIDTH   = 256,
  parameter int REMAINWIDTH = 20,
  parameter int ROUND_COUNT = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CWIDTH-1:0]            c_in,
  input  logic [RWIDTH-1:0]            r_in,
  input  logic [REMAINWIDTH-1:0]       remaining,
  input  logic [ROUND_COUNT-1:0]       rounds,
  output logic                         perm_go,
  output logic [CWIDTH-1:0]            perm_c,
  output logic [ROUND_COUNT-1:0]       perm_rounds,
  input  logic                         perm_done,
  input  logic [RWIDTH-1:0]            perm_r_in,
  input  logic [CWIDTH-1:0]            perm_c_in,
  output logic [RWIDTH-1:0]            out_data,
  output logic [$clog2(RWIDTH+1)-1:0]  out_len,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         Bdata,
  output logic [CWIDTH-1:0]            c_out,
  output logic                         busy,
  output logic                         squeeze_done
`ifdef SQUEEZE_PERM_COUNT_EN
  ,
  output logic [15:0]                  perm_count
`endif
);

  localparam int LW = $clog2(RWIDTH+1);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, EMIT = 3'd2, PERM = 3'd3, DONE = 3'd4;
  localparam logic [REMAINWIDTH-1:0] OUT_CAP = REMAINWIDTH'(OUT_WIDTH);
  localparam logic [REMAINWIDTH-1:0] R_CAP   = REMAINWIDTH'(RWIDTH);

  logic [2:0]             state;
  logic [RWIDTH-1:0]      r_reg;
  logic [CWIDTH-1:0]      c_reg;
  logic [ROUND_COUNT-1:0] rounds_reg;
  logic [REMAINWIDTH-1:0] rem;
  logic [REMAINWIDTH-1:0] pos;
  logic [OUT_WIDTH-1:0]   bdata;
  logic [REMAINWIDTH-1:0] rem_clamp;
  logic [REMAINWIDTH-1:0] len;
  logic [RWIDTH-1:0]      chunk;
  logic [OUT_WIDTH-1:0]   placed;
`ifdef SQUEEZE_PERM_COUNT_EN
  logic [15:0]            pcount;
`endif

  always_comb begin
    rem_clamp = (remaining > OUT_CAP) ? OUT_CAP : remaining;
    len       = (rem > R_CAP) ? R_CAP : rem;
    chunk     = r_reg & ~({RWIDTH{1'b1}} >> len);
    // Shifting the chunk down by RWIDTH+pos and keeping the low OUT_WIDTH bits
    // lands it at Bdata[OUT_WIDTH-1-pos -: len] without a variable-width slice.
    placed    = OUT_WIDTH'({chunk, {OUT_WIDTH{1'b0}}} >> (pos + R_CAP));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      r_reg      <= '0;
      c_reg      <= '0;
      rounds_reg <= '0;
      rem        <= '0;
      pos        <= '0;
      bdata      <= '0;
`ifdef SQUEEZE_PERM_COUNT_EN
      pcount     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: begin
          r_reg      <= r_in;
          c_reg      <= c_in;
          rounds_reg <= rounds;
          rem        <= rem_clamp;
          pos        <= '0;
          bdata      <= '0;
`ifdef SQUEEZE_PERM_COUNT_EN
          pcount     <= '0;
`endif
          state      <= (rem_clamp == '0) ? DONE : EMIT;
        end
        EMIT: if (out_ready) begin
          bdata <= bdata | placed;
          rem   <= rem - len;
          pos   <= pos + len;
          state <= (rem == len) ? DONE : PERM;
        end
        PERM: if (perm_done) begin
          r_reg <= perm_r_in;
          c_reg <= perm_c_in;
`ifdef SQUEEZE_PERM_COUNT_EN
          if (pcount != 16'hFFFF) pcount <= pcount + 16'd1;
`endif
          state <= EMIT;
        end
        DONE: if (start) begin
          bdata <= '0;
          state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid    = !reset && (state == EMIT);
  assign out_data     = chunk;
  assign out_len      = LW'(len);
  assign perm_go      = !reset && (state == PERM);
  assign perm_c       = c_reg;
  assign perm_rounds  = rounds_reg;
  assign Bdata        = reset ? '0 : bdata;
  assign c_out        = reset ? '0 : c_reg;
  assign busy         = !reset && (state == LOAD || state == EMIT || state == PERM);
  assign squeeze_done = !reset && (state == DONE);
`ifdef SQUEEZE_PERM_COUNT_EN
  assign perm_count   = pcount;
`endif

endmodule

// File: tb/tb_squeeze_stream.sv
// Directed bench for squeeze_stream: chunk scoreboard, permutation responder,
// bit-level Bdata model.
module tb_squeeze_stream;
  localparam int CW = 320, RW = 32, OW = 128, REMW = 20, RC = 10, LW = 6;

  logic clk = 1'b0;
  logic reset, start, perm_done, out_ready;
  logic [CW-1:0]   c_in, perm_c, perm_c_in, c_out;
  logic [RW-1:0]   r_in, perm_r_in, out_data;
  logic [REMW-1:0] remaining;
  logic [RC-1:0]   rounds, perm_rounds;
  logic [LW-1:0]   out_len;
  logic [OW-1:0]   Bdata;
  logic perm_go, out_valid, busy, squeeze_done;

  squeeze_stream #(.CWIDTH(CW), .RWIDTH(RW), .OUT_WIDTH(OW), .REMAINWIDTH(REMW), .ROUND_COUNT(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .c_in(c_in), .r_in(r_in),
    .remaining(remaining), .rounds(rounds), .perm_go(perm_go), .perm_c(perm_c),
    .perm_rounds(perm_rounds), .perm_done(perm_done), .perm_r_in(perm_r_in),
    .perm_c_in(perm_c_in), .out_data(out_data), .out_len(out_len),
    .out_valid(out_valid), .out_ready(out_ready), .Bdata(Bdata), .c_out(c_out),
    .busy(busy), .squeeze_done(squeeze_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [RW-1:0] d; logic [LW-1:0] l; } chunk_t;
  chunk_t        sb[$];
  logic [RW-1:0] perm_vals[$];
  logic [CW-1:0] perm_cvals[$];
  logic [CW-1:0] cur_c;
  int errors = 0, checks = 0, n_chunks = 0, perm_eps = 0;
  bit resp_en = 1'b1;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop one expected chunk per handshake.
  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_chunks++;
      if (sb.size() == 0) check("extra_chunk", CW'(sb.size()), CW'(1));
      else begin
        chunk_t e;
        e = sb.pop_front();
        check("chunk_data", CW'(out_data), CW'(e.d));
        check("chunk_len", CW'(out_len), CW'(e.l));
      end
    end
  end

  // Permutation responder: answers perm_go after two waiting cycles.
  initial begin
    int pdelay;
    pdelay = 0;
    perm_done = 1'b0; perm_r_in = '0; perm_c_in = '0;
    forever begin
      @(posedge clk); #1;
      perm_done = 1'b0;
      if (perm_go === 1'b1 && resp_en) begin
        if (pdelay == 2) begin
          pdelay = 0;
          check("perm_c", perm_c, cur_c);
          check("perm_rounds", CW'(perm_rounds), CW'(rounds));
          if (perm_vals.size() == 0) check("perm_vals_left", CW'(perm_vals.size()), CW'(1));
          else begin
            perm_r_in = perm_vals.pop_front();
            perm_c_in = perm_cvals.pop_front();
            cur_c = perm_c_in;
          end
          perm_done = 1'b1;
          perm_eps++;
        end else pdelay++;
      end else pdelay = 0;
    end
  end

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      if (squeeze_done === 1'b1) break;
      @(posedge clk); #1;
    end
    check({name, "_done"}, CW'(squeeze_done), CW'(1));
  endtask

  task automatic run(input string name, input logic [RW-1:0] r, input logic [CW-1:0] c,
                     input int req, input bit stall);
    logic [OW-1:0] exp_b;
    logic [RW-1:0] rate, d;
    logic [CW-1:0] cc;
    int rem, pos, len, idx, c0, p0;
    exp_b = '0; rate = r; cc = c; pos = 0; idx = 0;
    rem = (req > OW) ? OW : req;
    while (rem > 0) begin
      len = (rem > RW) ? RW : rem;
      d = '0;
      for (int i = 0; i < len; i++) begin
        d[RW-1-i] = rate[RW-1-i];
        exp_b[OW-1-pos-i] = rate[RW-1-i];
      end
      sb.push_back('{d, LW'(len)});
      pos += len; rem -= len;
      if (rem > 0) begin rate = perm_vals[idx]; cc = perm_cvals[idx]; idx++; end
    end
    c0 = n_chunks; p0 = perm_eps; cur_c = c;
    r_in = r; c_in = c; remaining = REMW'(req); rounds = RC'(req + 3);
    out_ready = !stall;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_load"}, CW'(busy), CW'(1));
    check({name, "_notdone_load"}, CW'(squeeze_done), CW'(0));
    if (req == 0) begin
      @(posedge clk); #1;
      check({name, "_done_2cyc"}, CW'(squeeze_done), CW'(1));
    end
    if (stall) begin
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin @(posedge clk); #1; end
      for (int i = 0; i < 5; i++) begin
        check({name, "_stall_valid"}, CW'(out_valid), CW'(1));
        check({name, "_stall_data"}, CW'(out_data), CW'(sb[0].d));
        check({name, "_stall_len"}, CW'(out_len), CW'(sb[0].l));
        check({name, "_stall_bdata"}, CW'(Bdata), CW'(0));
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
    end
    wait_done(name);
    @(posedge clk); #1;
    check({name, "_still_done"}, CW'(squeeze_done), CW'(1));
    check({name, "_bdata"}, CW'(Bdata), CW'(exp_b));
    check({name, "_c_out"}, c_out, cc);
    check({name, "_nchunks"}, CW'(n_chunks - c0), CW'(sb.size() + n_chunks - c0 == 0 ? 0 : (idx + ((req > 0) ? 1 : 0))));
    check({name, "_sb_empty"}, CW'(sb.size()), CW'(0));
    check({name, "_perm_eps"}, CW'(perm_eps - p0), CW'(idx));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    c_in = '0; r_in = '0; remaining = '0; rounds = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", CW'(out_valid), CW'(0));
    check("rst_perm_go", CW'(perm_go), CW'(0));
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_done", CW'(squeeze_done), CW'(0));
    check("rst_bdata", CW'(Bdata), CW'(0));
    check("rst_c_out", c_out, CW'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", CW'(busy), CW'(0));

    // Single chunk, no permutation.
    run("one", 32'hDEADBEEF, CW'(320'h1234), 32, 1'b0);
    check("one_top", CW'(Bdata[127:96]), CW'(32'hDEADBEEF));

    // Three chunks 32/32/8 with two permutations.
    perm_vals.push_back(32'h11111111); perm_cvals.push_back(CW'(320'hC1));
    perm_vals.push_back(32'h22222222); perm_cvals.push_back(CW'(320'hC2));
    run("seventy2", 32'hA5A5A5A5, CW'(320'hC0), 72, 1'b0);
    check("seventy2_tail", CW'(Bdata[63:56]), CW'(8'h22));
    check("seventy2_low", CW'(Bdata[55:0]), CW'(0));

    // Zero length, started from DONE so Bdata must be cleared.
    run("zero", 32'hFFFFFFFF, CW'(320'h77), 0, 1'b0);

    // Back-pressure on the first chunk of a 40-bit squeeze.
    perm_vals.push_back(32'hF0E1D2C3); perm_cvals.push_back(CW'(320'hBEEF));
    run("stall", 32'h0BADF00D, CW'(320'h55), 40, 1'b1);

    // Over-long request clamps to OUT_WIDTH.
    perm_vals.push_back(32'h01234567); perm_cvals.push_back(CW'(320'hA1));
    perm_vals.push_back(32'h89ABCDEF); perm_cvals.push_back(CW'(320'hA2));
    perm_vals.push_back(32'h13579BDF); perm_cvals.push_back(CW'(320'hA3));
    run("clamp", 32'hFEDCBA98, CW'(320'hA0), 1000, 1'b0);

    // Reset while perm_go is high.
    resp_en = 1'b0;
    sb.push_back('{32'hCAFEF00D, LW'(32)});
    cur_c = CW'(320'h99);
    r_in = 32'hCAFEF00D; c_in = CW'(320'h99); remaining = REMW'(72); rounds = RC'(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && perm_go !== 1'b1; i++) begin @(posedge clk); #1; end
    check("rst_mid_perm_go_seen", CW'(perm_go), CW'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_perm_go", CW'(perm_go), CW'(0));
    check("rst_mid_bdata", CW'(Bdata), CW'(0));
    check("rst_mid_busy", CW'(busy), CW'(0));
    @(posedge clk); #1;
    check("rst_mid_idle", CW'(busy | squeeze_done | out_valid), CW'(0));
    sb.delete(); perm_vals.delete(); perm_cvals.delete();
    resp_en = 1'b1;
    perm_vals.push_back(32'h5A5A5A5A); perm_cvals.push_back(CW'(320'hD1));
    run("fresh", 32'h87654321, CW'(320'hD0), 64, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
